flit_depacketizer: RTL and testbench
====================================

Name: flit_depacketizer

Overview:
- Parametrised, handshaked successor to the fixed 256-bit head/body/tail depacketizer.
- Accepts one flit per cycle on a valid/ready input from the NoC router's ejection port.
- Validates head → body×N → tail framing and extracts a DATA_W payload word from each body flit onto a valid/ready output stream.
- Flags end-of-packet and framing errors, and keeps packet/error statistics for the NI status registers.

Parameters:
- FLIT_W, 256, flit width in bits; must be ≥ DATA_W+18.
- DATA_W, 16, payload word extracted per body flit.
- LEN_W, 8, width of the head-flit body-length field.
- TAIL_MARK, 16'hFFFF, required value of tail flit[15:0].
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flit_in  in  FLIT_W  incoming flit
- flit_valid  in  1  flit_in valid
- flit_ready  out  1  block accepts flit this cycle
- data_out  out  DATA_W  reconstructed payload word
- data_valid  out  1  data_out valid
- data_ready  in  1  downstream accepts data_out
- data_last  out  1  data_out is the final word of its packet
- packet_end  out  1  1-cycle pulse: tail accepted with correct marker
- err  out  1  1-cycle pulse: framing error detected
- err_code  out  2  error cause, valid when err=1
- pkt_count  out  CNT_W  good packets completed
- err_count  out  CNT_W  errors detected

Behaviour:
- Reset: sync, active-high; interface is one clock (clk) and one synchronous active-high reset (reset).
  - On reset: state=IDLE; data_valid, data_last, packet_end, err, err_code, pkt_count, err_count, and data_out all 0.
  - Reset mid-packet discards the partial packet; no error is counted.
- Flit fields:
  - type = flit_in[17:16]: 01 head, 00 body, 10 tail, 11 reserved.
  - Payload = flit_in[FLIT_W-1 -: DATA_W].
  - Head length L = flit_in[FLIT_W-1 -: LEN_W].
  - Tail marker = flit_in[15:0].
- Accept condition: flit_valid && flit_ready.
  - flit_ready = 1 in IDLE, TAIL and DROP.
  - flit_ready = (!data_valid || data_ready) in BODY (single output register, no bubble under continuous ready).
- Output register:
  - Loaded on an accepted body flit in BODY; data_out visible the next cycle (latency 1).
  - data_valid holds with data_out/data_last stable until data_ready.
- FSM:
  - IDLE:
    - head: latch L, clear beat counter; go to BODY if L≠0, else TAIL.
    - body/tail/reserved: err, err_code=1 (no head); stay IDLE.
  - BODY:
    - body: emit payload; data_last=1 when beat counter reaches L-1; after last, go to TAIL; else increment counter.
    - head: err, err_code=2 (early head); restart as a new packet with the new L (same rules as IDLE head).
    - tail or reserved: err, err_code=3 (short packet); go to IDLE; no data_last is emitted.
  - TAIL:
    - tail with marker==TAIL_MARK: packet_end pulse, pkt_count+1, go to IDLE.
    - tail with a wrong marker: err, err_code=3; go to IDLE.
    - body (long packet): err, err_code=3; go to DROP.
    - head: err, err_code=2; handle as a new head.
  - DROP:
    - Consume and discard flits until a tail (then go to IDLE) or a head (handled as a new head, no extra error).
- Outputs: packet_end and err are registered, asserted the cycle after the offending or valid flit is accepted, and high for exactly 1 cycle. At most one error per accepted flit.
- Counters: err_count increments with every err pulse. Both counters saturate at all-ones (no wrap).
- Max packet: L=2^LEN_W-1 body beats; the beat counter is LEN_W bits and never wraps within a legal packet.

Test Plan:
- Head L=3, bodies with payloads 16'hA001/A002/A003, tail 16'hFFFF, data_ready=1 → data_out A001,A002,A003 on consecutive cycles, data_last only on A003, packet_end pulse after tail, pkt_count=1, no err.
- Same packet with data_ready held 0 for 5 cycles after first beat → A001 held stable, flit_ready=0 in BODY, no word lost or duplicated, order preserved.
- Head L=0 then tail FFFF → no data_valid, packet_end pulse, pkt_count=1.
- Body in IDLE → err, err_code=1, err_count=1. Head L=2, one body, then head L=1 → err_code=2 after the second head, and the second packet then completes normally.
- Head L=1, body, tail marker 16'h1234 → data_last beat emitted, err_code=3, packet_end never asserted. Head L=1, two bodies, tail → err_code=3, DROP, second body not emitted, IDLE after tail.
- Assert reset for 1 cycle after the second body of an L=4 packet → all outputs 0 next cycle; a fresh head L=1/body/tail then completes with pkt_count=1.

Source files
------------

// File: rtl/flit_depacketizer.sv
// Head/body/tail flit depacketizer: checks packet framing, streams one payload word
// per body flit over valid/ready, and keeps good-packet and error counts.
module flit_depacketizer #(
  parameter int unsigned FLIT_W    = 256,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned LEN_W     = 8,
  parameter logic [15:0] TAIL_MARK = 16'hFFFF,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLIT_W-1:0] flit_in,
  input  logic              flit_valid,
  output logic              flit_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              data_last,
  output logic              packet_end,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [CNT_W-1:0]  err_count
);

  localparam logic [1:0] T_BODY = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;

  localparam logic [1:0] E_NO_HEAD    = 2'd1;
  localparam logic [1:0] E_EARLY_HEAD = 2'd2;
  localparam logic [1:0] E_LENGTH     = 2'd3;

  typedef enum logic [1:0] {IDLE, BODY, TAIL, DROP} state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [DATA_W-1:0] data_out_d;
  logic              data_valid_d, data_last_d, packet_end_d, err_d;
  logic [1:0]        err_code_d;
  logic [CNT_W-1:0]  pkt_count_d, err_count_d;

  logic [1:0]        ftype;
  logic [LEN_W-1:0]  head_len;
  logic              accept, start_pkt, last_beat;
  logic              unused_flit;

  assign ftype       = flit_in[17:16];
  assign head_len    = flit_in[FLIT_W-1 -: LEN_W];
  assign unused_flit = ^flit_in;

  // Next-state, output-register and counter logic for every accepted flit.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    beat_d       = beat_q;
    data_out_d   = data_out;
    data_valid_d = data_valid && !data_ready;
    data_last_d  = data_last;
    packet_end_d = 1'b0;
    err_d        = 1'b0;
    err_code_d   = 2'd0;
    pkt_count_d  = pkt_count;
    err_count_d  = err_count;
    start_pkt    = 1'b0;
    last_beat    = (beat_q == len_q - LEN_W'(1));

    // BODY stalls only when the single output register is full and not draining.
    flit_ready = (state_q == BODY) ? (!data_valid || data_ready) : 1'b1;
    accept     = flit_valid && flit_ready;

    if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (ftype == T_HEAD) begin
            start_pkt = 1'b1;
          end else begin
            err_d      = 1'b1;
            err_code_d = E_NO_HEAD;
          end
        end
        BODY: begin
          case (ftype)
            T_BODY: begin
              data_out_d   = flit_in[FLIT_W-1 -: DATA_W];
              data_valid_d = 1'b1;
              data_last_d  = last_beat;
              if (last_beat) state_d = TAIL;
              else           beat_d  = beat_q + LEN_W'(1);
            end
            T_HEAD: begin
              err_d      = 1'b1;
              err_code_d = E_EARLY_HEAD;
              start_pkt  = 1'b1;
            end
            default: begin
              err_d      = 1'b1;
              err_code_d = E_LENGTH;
              state_d    = IDLE;
            end
          endcase
        end
        TAIL: begin
          case (ftype)
            T_TAIL: begin
              state_d = IDLE;
              if (flit_in[15:0] == TAIL_MARK) begin
                packet_end_d = 1'b1;
              end else begin
                err_d      = 1'b1;
                err_code_d = E_LENGTH;
              end
            end
            T_HEAD: begin
              err_d      = 1'b1;
              err_code_d = E_EARLY_HEAD;
              start_pkt  = 1'b1;
            end
            default: begin
              err_d      = 1'b1;
              err_code_d = E_LENGTH;
              state_d    = DROP;
            end
          endcase
        end
        DROP: begin
          if (ftype == T_TAIL)      state_d   = IDLE;
          else if (ftype == T_HEAD) start_pkt = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    // A head always opens a fresh packet; zero length goes straight to the tail.
    if (start_pkt) begin
      len_d  = head_len;
      beat_d = '0;
      if (head_len != '0) state_d = BODY;
      else                state_d = TAIL;
    end

    if (packet_end_d && (pkt_count != '1)) pkt_count_d = pkt_count + CNT_W'(1);
    if (err_d && (err_count != '1))        err_count_d = err_count + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      beat_q     <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      data_last  <= 1'b0;
      packet_end <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'd0;
      pkt_count  <= '0;
      err_count  <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      beat_q     <= beat_d;
      data_out   <= data_out_d;
      data_valid <= data_valid_d;
      data_last  <= data_last_d;
      packet_end <= packet_end_d;
      err        <= err_d;
      err_code   <= err_code_d;
      pkt_count  <= pkt_count_d;
      err_count  <= err_count_d;
    end
  end

endmodule

// File: tb/tb_flit_depacketizer.sv
// Bench for flit_depacketizer: directed packet cases plus randomized packet scenarios
// whose expected words, errors and counts come from a packet-level model.
module tb_flit_depacketizer;
  localparam int unsigned FLIT_W = 256;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned LEN_W  = 8;
  localparam int unsigned CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [FLIT_W-1:0] flit_in;
  logic              flit_valid;
  logic              flit_ready;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              data_ready;
  logic              data_last;
  logic              packet_end;
  logic              err;
  logic [1:0]        err_code;
  logic [CNT_W-1:0]  pkt_count;
  logic [CNT_W-1:0]  err_count;

  flit_depacketizer #(.FLIT_W(FLIT_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
                      .TAIL_MARK(16'hFFFF), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flit_in(flit_in), .flit_valid(flit_valid),
    .flit_ready(flit_ready), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .data_last(data_last), .packet_end(packet_end),
    .err(err), .err_code(err_code), .pkt_count(pkt_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {logic [15:0] d; logic l;} word_t;
  typedef struct {logic [1:0] t; logic [15:0] hi; logic [15:0] lo;} fl_t;

  int passed = 0, total = 0, cyc = 0;
  word_t exp_w[$], obs_w[$];
  int    obs_t[$], exp_e[$], obs_e[$];
  fl_t   fq[$];
  int    exp_pend, obs_pend, exp_pkt, exp_errc, stab_err;
  logic  prev_hold = 1'b0, prev_l = 1'b0;
  logic [15:0] prev_d = '0;
  logic  rdy_rand = 1'b0, rdy_val = 1'b1, rnd_bit = 1'b1;

  assign data_ready = rdy_rand ? rnd_bit : rdy_val;

  always @(posedge clk) begin
    #1;
    rnd_bit = ($urandom_range(3) != 0);
  end

  // Monitor: records transferred words, error pulses and packet_end pulses.
  always @(negedge clk) begin
    word_t w;
    cyc++;
    if (!reset) begin
      if (prev_hold && (!data_valid || data_out !== prev_d || data_last !== prev_l)) stab_err++;
      if (data_valid && data_ready) begin
        w.d = data_out; w.l = data_last;
        obs_w.push_back(w);
        obs_t.push_back(cyc);
      end
      if (err) obs_e.push_back(int'(err_code));
      if (packet_end) obs_pend++;
    end
    prev_hold = !reset && data_valid && !data_ready;
    prev_d    = data_out;
    prev_l    = data_last;
  end

  function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t, input logic [15:0] hi,
                                           input logic [15:0] lo);
    logic [FLIT_W-1:0] f;
    f = '0;
    f[FLIT_W-1 -: 16] = hi;
    f[17:16] = t;
    f[15:0]  = lo;
    return f;
  endfunction

  task automatic clear_obs();
    obs_w.delete(); obs_t.delete(); obs_e.delete(); exp_w.delete(); exp_e.delete();
    obs_pend = 0; exp_pend = 0; stab_err = 0;
  endtask

  task automatic do_reset();
    flit_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_obs();
    exp_pkt = 0; exp_errc = 0;
  endtask

  task automatic send(input logic [1:0] t, input logic [15:0] hi, input logic [15:0] lo);
    bit done = 0;
    flit_in = mk(t, hi, lo);
    flit_valid = 1'b1;
    for (int n = 0; n < 500 && !done; n++) begin
      @(negedge clk);
      done = flit_ready;
      @(posedge clk);
      #1;
    end
    flit_valid = 1'b0;
    if (!done) begin
      total++;
      $display("FAIL send_timeout: flit type %0d not accepted in 500 cycles, required accept", t);
    end
  endtask

  task automatic idle(input int n);
    flit_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(output bit to);
    to = 1;
    for (int n = 0; n < 3000; n++) begin
      if (obs_w.size() >= exp_w.size()) begin to = 0; break; end
      @(posedge clk);
      #1;
    end
    idle(4);
  endtask

  // Packet-level reference model: each helper queues flits and their expected effects.
  task automatic m_head(input int len);
    fl_t x;
    x.t = 2'b01; x.hi = {8'(len), 8'($urandom)}; x.lo = 16'($urandom);
    fq.push_back(x);
  endtask

  task automatic m_body(input bit emit, input bit last);
    fl_t x; word_t w;
    x.t = 2'b00; x.hi = 16'($urandom); x.lo = 16'($urandom);
    fq.push_back(x);
    if (emit) begin w.d = x.hi; w.l = last; exp_w.push_back(w); end
  endtask

  task automatic m_tail(input logic [15:0] m);
    fl_t x;
    x.t = 2'b10; x.hi = 16'($urandom); x.lo = m;
    fq.push_back(x);
  endtask

  task automatic m_err(input int c);
    exp_e.push_back(c);
    exp_errc++;
  endtask

  task automatic m_good(input int len);
    m_head(len);
    for (int i = 0; i < len; i++) m_body(1, i == len - 1);
    m_tail(16'hFFFF);
    exp_pend++; exp_pkt++;
  endtask

  task automatic gen_scenario(input int kind);
    int len, k; logic [15:0] m; fl_t x;
    len = int'($urandom_range(6, 1));
    case (kind)
      0: m_good(len);
      1: m_good(0);
      2: begin
        k = int'($urandom_range(2, 0));
        x.t = (k == 0) ? 2'b00 : (k == 1) ? 2'b10 : 2'b11;
        x.hi = 16'($urandom); x.lo = 16'($urandom);
        fq.push_back(x);
        m_err(1);
      end
      3: begin
        k = int'($urandom_range(len - 1, 0));
        m_head(len);
        for (int i = 0; i < k; i++) m_body(1, 0);
        m_tail(16'hFFFF);
        m_err(3);
      end
      4: begin
        m_head(len);
        for (int i = 0; i < len; i++) m_body(1, i == len - 1);
        do m = 16'($urandom); while (m == 16'hFFFF);
        m_tail(m);
        m_err(3);
      end
      5: begin
        m_head(len);
        for (int i = 0; i < len; i++) m_body(1, i == len - 1);
        m_err(3);
        k = int'($urandom_range(3, 1));
        for (int i = 0; i < k; i++) m_body(0, 0);
        m_tail(16'($urandom));
      end
      default: begin
        k = int'($urandom_range(len, 0));
        m_head(len);
        for (int i = 0; i < k; i++) m_body(1, (k == len) && (i == k - 1));
        m_err(2);
        m_good(int'($urandom_range(4, 0)));
      end
    endcase
  endtask

  task automatic play();
    fl_t x;
    while (fq.size() > 0) begin
      x = fq.pop_front();
      if ($urandom_range(3) == 0) idle(int'($urandom_range(2, 1)));
      send(x.t, x.hi, x.lo);
    end
    flit_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++;
    if ({data_valid, data_last, packet_end, err} !== 4'b0) $display("FAIL reset_flags: got %b required 0000", {data_valid, data_last, packet_end, err});
    else passed++;
    total++;
    if ({data_out, err_code} !== 18'd0) $display("FAIL reset_data: got data %h code %0d required 0/0", data_out, err_code);
    else passed++;
    total++;
    if ({pkt_count, err_count} !== 32'd0) $display("FAIL reset_counts: got %0d/%0d required 0/0", pkt_count, err_count);
    else passed++;
    total++;
    if (flit_ready !== 1'b1) $display("FAIL reset_ready: got %b required 1", flit_ready);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [15:0] ev [3];
    bit ok = 1, consec = 1;
    ev[0] = 16'hA001; ev[1] = 16'hA002; ev[2] = 16'hA003;
    do_reset(); rdy_rand = 0; rdy_val = 1;
    send(2'b01, {8'd3, 8'h00}, 16'h0);
    for (int i = 0; i < 3; i++) send(2'b00, ev[i], 16'h0);
    send(2'b10, 16'h0, 16'hFFFF);
    idle(5);
    if (obs_w.size() != 3) ok = 0;
    else for (int i = 0; i < 3; i++) if (obs_w[i].d !== ev[i] || obs_w[i].l !== (i == 2)) ok = 0;
    total++;
    if (!ok) $display("FAIL basic_words: got %0d words (first %h) required A001,A002,A003 last on third", obs_w.size(), (obs_w.size() > 0) ? obs_w[0].d : 16'h0);
    else passed++;
    if (obs_t.size() == 3) consec = (obs_t[1] == obs_t[0] + 1) && (obs_t[2] == obs_t[1] + 1);
    else consec = 0;
    total++;
    if (!consec) $display("FAIL basic_timing: word cycles not consecutive, %0d stamps required 3 consecutive", obs_t.size());
    else passed++;
    total++;
    if (obs_pend != 1 || pkt_count !== 16'd1) $display("FAIL basic_end: got %0d pulses count %0d required 1/1", obs_pend, pkt_count);
    else passed++;
    total++;
    if (obs_e.size() != 0 || err_count !== 16'd0) $display("FAIL basic_noerr: got %0d errs count %0d required 0/0", obs_e.size(), err_count);
    else passed++;
  endtask

  task automatic test_backpressure();
    bit hold_ok = 1, ok = 1;
    do_reset(); rdy_rand = 0; rdy_val = 0;
    send(2'b01, {8'd3, 8'h00}, 16'h0);
    send(2'b00, 16'hA001, 16'h0);
    flit_in = mk(2'b00, 16'hA002, 16'h0);
    flit_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (flit_ready !== 1'b0 || data_valid !== 1'b1 || data_out !== 16'hA001) hold_ok = 0;
      @(posedge clk); #1;
    end
    rdy_val = 1;
    send(2'b00, 16'hA002, 16'h0);
    send(2'b00, 16'hA003, 16'h0);
    send(2'b10, 16'h0, 16'hFFFF);
    idle(5);
    total++;
    if (!hold_ok) $display("FAIL bp_hold: flit_ready %b valid %b data %h, required 0/1/A001 while stalled", flit_ready, data_valid, data_out);
    else passed++;
    if (obs_w.size() != 3) ok = 0;
    else ok = obs_w[0].d === 16'hA001 && obs_w[1].d === 16'hA002 && obs_w[2].d === 16'hA003 && obs_w[2].l === 1'b1 && obs_w[0].l === 1'b0;
    total++;
    if (!ok) $display("FAIL bp_words: got %0d words required A001,A002,A003 in order", obs_w.size());
    else passed++;
    total++;
    if (stab_err != 0) $display("FAIL bp_stable: %0d unstable held cycles, required 0", stab_err);
    else passed++;
    total++;
    if (pkt_count !== 16'd1) $display("FAIL bp_count: got %0d required 1", pkt_count);
    else passed++;
  endtask

  task automatic test_zero_len();
    do_reset(); rdy_rand = 0; rdy_val = 1;
    send(2'b01, {8'd0, 8'h5A}, 16'h0);
    send(2'b10, 16'h0, 16'hFFFF);
    idle(4);
    total++;
    if (obs_w.size() != 0) $display("FAIL zero_words: got %0d words required 0", obs_w.size());
    else passed++;
    total++;
    if (obs_pend != 1 || pkt_count !== 16'd1) $display("FAIL zero_end: got %0d pulses count %0d required 1/1", obs_pend, pkt_count);
    else passed++;
    total++;
    if (obs_e.size() != 0) $display("FAIL zero_err: got %0d errs required 0", obs_e.size());
    else passed++;
  endtask

  task automatic test_errors();
    do_reset(); rdy_rand = 0; rdy_val = 1;
    send(2'b00, 16'h1234, 16'h0);
    idle(3);
    total++;
    if (obs_e.size() != 1 || obs_e[0] != 1 || err_count !== 16'd1) $display("FAIL nohead_err: got %0d errs count %0d required code 1 count 1", obs_e.size(), err_count);
    else passed++;
    send(2'b01, {8'd2, 8'h00}, 16'h0);
    send(2'b00, 16'hB001, 16'h0);
    send(2'b01, {8'd1, 8'h00}, 16'h0);
    send(2'b00, 16'hB002, 16'h0);
    send(2'b10, 16'h0, 16'hFFFF);
    idle(4);
    total++;
    if (obs_e.size() != 2 || obs_e[1] != 2) $display("FAIL early_err: got %0d errs (last %0d) required 2 with code 2", obs_e.size(), (obs_e.size() > 0) ? obs_e[obs_e.size()-1] : 0);
    else passed++;
    total++;
    if (obs_w.size() != 2 || obs_w[0].d !== 16'hB001 || obs_w[0].l !== 1'b0 || obs_w[1].d !== 16'hB002 || obs_w[1].l !== 1'b1)
      $display("FAIL early_words: got %0d words required B001(not last),B002(last)", obs_w.size());
    else passed++;
    total++;
    if (pkt_count !== 16'd1 || err_count !== 16'd2) $display("FAIL early_counts: got %0d/%0d required 1/2", pkt_count, err_count);
    else passed++;
  endtask

  task automatic test_len_errors();
    do_reset(); rdy_rand = 0; rdy_val = 1;
    send(2'b01, {8'd1, 8'h00}, 16'h0);
    send(2'b00, 16'hC001, 16'h0);
    send(2'b10, 16'h0, 16'h1234);
    idle(4);
    total++;
    if (obs_w.size() != 1 || obs_w[0].d !== 16'hC001 || obs_w[0].l !== 1'b1) $display("FAIL badmark_word: got %0d words required C001 with last", obs_w.size());
    else passed++;
    total++;
    if (obs_e.size() != 1 || obs_e[0] != 3 || obs_pend != 0) $display("FAIL badmark_err: got %0d errs %0d ends required code 3 and no end", obs_e.size(), obs_pend);
    else passed++;
    clear_obs();
    send(2'b01, {8'd1, 8'h00}, 16'h0);
    send(2'b00, 16'hC002, 16'h0);
    send(2'b00, 16'hC003, 16'h0);
    send(2'b10, 16'h0, 16'hFFFF);
    send(2'b00, 16'hC004, 16'h0);
    idle(4);
    total++;
    if (obs_w.size() != 1 || obs_w[0].d !== 16'hC002) $display("FAIL long_words: got %0d words required only C002", obs_w.size());
    else passed++;
    total++;
    if (obs_e.size() != 2 || obs_e[0] != 3 || obs_e[1] != 1) $display("FAIL long_errs: got %0d errs required codes 3 then 1", obs_e.size());
    else passed++;
    total++;
    if (pkt_count !== 16'd0 || err_count !== 16'd3 || obs_pend != 0) $display("FAIL long_counts: got %0d/%0d required 0/3", pkt_count, err_count);
    else passed++;
  endtask

  task automatic test_mid_reset();
    do_reset(); rdy_rand = 0; rdy_val = 1;
    send(2'b01, {8'd1, 8'h00}, 16'h0);
    send(2'b00, 16'hD000, 16'h0);
    send(2'b10, 16'h0, 16'hFFFF);
    send(2'b10, 16'h0, 16'hFFFF);
    send(2'b01, {8'd4, 8'h00}, 16'h0);
    send(2'b00, 16'hD001, 16'h0);
    send(2'b00, 16'hD002, 16'h0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    total++;
    if ({data_valid, data_last, packet_end, err, err_code} !== 6'd0 || data_out !== 16'd0)
      $display("FAIL midreset_out: got v%b l%b e%b err%b code %0d data %h required all 0", data_valid, data_last, packet_end, err, err_code, data_out);
    else passed++;
    total++;
    if (pkt_count !== 16'd0 || err_count !== 16'd0) $display("FAIL midreset_counts: got %0d/%0d required 0/0", pkt_count, err_count);
    else passed++;
    @(posedge clk); #1;
    clear_obs();
    send(2'b01, {8'd1, 8'h00}, 16'h0);
    send(2'b00, 16'hE001, 16'h0);
    send(2'b10, 16'h0, 16'hFFFF);
    idle(4);
    total++;
    if (obs_w.size() != 1 || obs_w[0].d !== 16'hE001 || pkt_count !== 16'd1 || err_count !== 16'd0)
      $display("FAIL midreset_fresh: got %0d words counts %0d/%0d required 1 word E001 and 1/0", obs_w.size(), pkt_count, err_count);
    else passed++;
  endtask

  task automatic test_random();
    bit to; int kind, bad, n;
    do_reset(); rdy_rand = 1;
    for (int s = 0; s < 80; s++) begin
      kind = int'($urandom_range(6, 0));
      gen_scenario(kind);
      play();
      drain(to);
      total++;
      if (to) $display("FAIL rand_drain scen %0d kind %0d: %0d words seen, %0d required", s, kind, obs_w.size(), exp_w.size());
      else passed++;
      bad = -1;
      n = (obs_w.size() < exp_w.size()) ? obs_w.size() : exp_w.size();
      for (int i = 0; i < n; i++) if (bad < 0 && (obs_w[i].d !== exp_w[i].d || obs_w[i].l !== exp_w[i].l)) bad = i;
      if (bad < 0 && obs_w.size() != exp_w.size()) bad = n;
      total++;
      if (bad >= 0) $display("FAIL rand_words scen %0d kind %0d: %0d words seen, %0d required, first difference at %0d", s, kind, obs_w.size(), exp_w.size(), bad);
      else passed++;
      bad = (obs_e.size() != exp_e.size()) ? 1 : 0;
      if (bad == 0) for (int i = 0; i < obs_e.size(); i++) if (obs_e[i] != exp_e[i]) bad = 1;
      total++;
      if (bad != 0) $display("FAIL rand_errs scen %0d kind %0d: %0d errs seen (first %0d), %0d required (first %0d)", s, kind, obs_e.size(), (obs_e.size() > 0) ? obs_e[0] : 0, exp_e.size(), (exp_e.size() > 0) ? exp_e[0] : 0);
      else passed++;
      total++;
      if (obs_pend != exp_pend) $display("FAIL rand_end scen %0d kind %0d: got %0d pulses required %0d", s, kind, obs_pend, exp_pend);
      else passed++;
      total++;
      if (pkt_count !== CNT_W'(exp_pkt) || err_count !== CNT_W'(exp_errc)) $display("FAIL rand_counts scen %0d: got %0d/%0d required %0d/%0d", s, pkt_count, err_count, exp_pkt, exp_errc);
      else passed++;
      total++;
      if (stab_err != 0) $display("FAIL rand_stable scen %0d: %0d unstable held cycles required 0", s, stab_err);
      else passed++;
      clear_obs();
    end
  endtask

  task automatic test_max_len();
    bit to, ok = 1;
    do_reset(); rdy_rand = 1;
    m_good(255);
    play();
    drain(to);
    if (to || obs_w.size() != 255) ok = 0;
    else for (int i = 0; i < 255; i++) if (obs_w[i].d !== exp_w[i].d || obs_w[i].l !== (i == 254)) ok = 0;
    total++;
    if (!ok) $display("FAIL maxlen_words: got %0d words required 255 with last only on final", obs_w.size());
    else passed++;
    total++;
    if (obs_pend != 1 || pkt_count !== 16'd1 || obs_e.size() != 0) $display("FAIL maxlen_end: got %0d ends count %0d errs %0d required 1/1/0", obs_pend, pkt_count, obs_e.size());
    else passed++;
    rdy_rand = 0;
  endtask

  initial begin
    reset = 1'b1; flit_valid = 1'b0; flit_in = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_len();
    test_errors();
    test_len_errors();
    test_mid_reset();
    test_random();
    test_max_len();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded 50000 cycles, required completion");
    $fatal(1);
  end

endmodule
